// File: rtl/layer2_result_collector.sv
// layer2_result_collector
// Consumer end of the layer-2 8-lane conv MAC array. It accumulates GROUPS
// per-beat lane outputs into one pixel, then saturates each lane to 16 bits
// and optionally applies ReLU. The eight results are packed into a 128-bit
// word and handed downstream over a valid/ready handshake.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   in_valid / in_ready           beat handshake from the MAC array
//   in_channel1..in_channel8      signed Q5.10 lane results
//   out_valid / out_ready         word handshake to the output buffer
//   out_data                      lane1 in [127:112] ... lane8 in [15:0]
//   out_group_cnt                 beats accumulated so far for the current word
module layer2_result_collector #(
    parameter int unsigned WORDLENGTH = 16,
    parameter int unsigned GROUPS     = 4,
    parameter int unsigned ACC_WIDTH  = 20,
    parameter int unsigned RELU_EN    = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WORDLENGTH-1:0]   in_channel1,
    input  logic [WORDLENGTH-1:0]   in_channel2,
    input  logic [WORDLENGTH-1:0]   in_channel3,
    input  logic [WORDLENGTH-1:0]   in_channel4,
    input  logic [WORDLENGTH-1:0]   in_channel5,
    input  logic [WORDLENGTH-1:0]   in_channel6,
    input  logic [WORDLENGTH-1:0]   in_channel7,
    input  logic [WORDLENGTH-1:0]   in_channel8,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*WORDLENGTH-1:0] out_data,
    output logic [3:0]              out_group_cnt
);

    localparam int unsigned LANES = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned EXT_W = ACC_WIDTH - WORDLENGTH;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (WORDLENGTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        S_ACC  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                      state;
    logic [WORDLENGTH-1:0]       lane_in [LANES];
    logic signed [ACC_WIDTH-1:0] acc     [LANES];
    logic signed [ACC_WIDTH-1:0] sum     [LANES];
    logic [8*WORDLENGTH-1:0]     word_c;
    logic                        last_beat;
    logic                        accept;
    logic                        final_beat;

    assign lane_in[0] = in_channel1;
    assign lane_in[1] = in_channel2;
    assign lane_in[2] = in_channel3;
    assign lane_in[3] = in_channel4;
    assign lane_in[4] = in_channel5;
    assign lane_in[5] = in_channel6;
    assign lane_in[6] = in_channel7;
    assign lane_in[7] = in_channel8;

    // Saturate an accumulated lane to WORDLENGTH bits, then optionally clamp negatives.
    function automatic logic [WORDLENGTH-1:0] saturate(input logic signed [ACC_WIDTH-1:0] v);
        logic [WORDLENGTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[WORDLENGTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[WORDLENGTH-1:0];
        end else begin
            r = v[WORDLENGTH-1:0];
        end
        if ((RELU_EN != 0) && r[WORDLENGTH-1]) begin
            r = '0;
        end
        return r;
    endfunction

    assign out_valid  = (state == S_HOLD);
    assign last_beat  = (out_group_cnt == CNT_W'(GROUPS - 1));
    // Only a final beat that would overwrite an unconsumed word is held off.
    assign in_ready   = !(out_valid && !out_ready && last_beat);
    assign accept     = in_valid && in_ready;
    assign final_beat = accept && last_beat;

    // Running sums including the current beat, plus the packed word they would produce.
    always_comb begin
        word_c = '0;
        for (int i = 0; i < LANES; i++) begin
            sum[i] = acc[i] + $signed({{EXT_W{lane_in[i][WORDLENGTH-1]}}, lane_in[i]});
            word_c[(LANES-1-i)*WORDLENGTH +: WORDLENGTH] = saturate(sum[i]);
        end
    end

    // Accumulators, output word and ACC/HOLD state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_ACC;
            out_data      <= '0;
            out_group_cnt <= '0;
            for (int i = 0; i < LANES; i++) begin
                acc[i] <= '0;
            end
        end else begin
            if (accept) begin
                if (last_beat) begin
                    out_data      <= word_c;
                    out_group_cnt <= '0;
                    for (int i = 0; i < LANES; i++) begin
                        acc[i] <= '0;
                    end
                end else begin
                    out_group_cnt <= out_group_cnt + CNT_W'(1);
                    for (int i = 0; i < LANES; i++) begin
                        acc[i] <= sum[i];
                    end
                end
            end

            // A final beat landing with the consume keeps HOLD: no bubble between words.
            case (state)
                S_ACC:   if (final_beat) state <= S_HOLD;
                S_HOLD:  if (out_ready && !final_beat) state <= S_ACC;
                default: state <= S_ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_layer2_result_collector.sv
// Testbench for layer2_result_collector: two instances (ReLU on / off) share
// stimulus and are checked every cycle against a sum-and-saturate reference.
module tb_layer2_result_collector;

    localparam int unsigned G = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic [15:0]  lane  [8];
    logic [15:0]  stage [8];

    logic         in_ready,  in_ready_nr;
    logic         out_valid, out_valid_nr;
    logic [127:0] out_data,  out_data_nr;
    logic [3:0]   out_group_cnt, out_group_cnt_nr;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit           m_valid;
    int           m_cnt;
    int           m_sum [8];
    logic [127:0] m_word, m_word_nr;

    always #5 clk = ~clk;

    layer2_result_collector #(.GROUPS(G), .RELU_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_channel1(lane[0]), .in_channel2(lane[1]), .in_channel3(lane[2]), .in_channel4(lane[3]),
        .in_channel5(lane[4]), .in_channel6(lane[5]), .in_channel7(lane[6]), .in_channel8(lane[7]),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_group_cnt(out_group_cnt)
    );

    layer2_result_collector #(.GROUPS(G), .RELU_EN(0)) dut_nr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_nr),
        .in_channel1(lane[0]), .in_channel2(lane[1]), .in_channel3(lane[2]), .in_channel4(lane[3]),
        .in_channel5(lane[4]), .in_channel6(lane[5]), .in_channel7(lane[6]), .in_channel8(lane[7]),
        .out_valid(out_valid_nr), .out_ready(out_ready), .out_data(out_data_nr),
        .out_group_cnt(out_group_cnt_nr)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Clip each lane sum to the int16 range, optionally zero negatives, pack lane1 on top.
    function automatic logic [127:0] pack_word(input int s [8], input bit relu);
        logic [127:0] w;
        int r;
        w = '0;
        for (int i = 0; i < 8; i++) begin
            r = s[i];
            if (r > 32767)  r = 32767;
            if (r < -32768) r = -32768;
            if (relu && r < 0) r = 0;
            w[127 - 16*i -: 16] = 16'(r);
        end
        return w;
    endfunction

    task automatic model_clear();
        m_valid = 1'b0;
        m_cnt   = 0;
        for (int i = 0; i < 8; i++) m_sum[i] = 0;
    endtask

    // One clock: drive at negedge, check outputs, then advance the model for the coming edge.
    task automatic step(input bit v, input bit ordy);
        bit exp_rdy;
        bit produced;
        @(negedge clk);
        in_valid  = v;
        out_ready = ordy;
        for (int i = 0; i < 8; i++) lane[i] = stage[i];
        #1;
        exp_rdy = !(m_valid && !ordy && (m_cnt == G - 1));
        check_eq("in_ready",         in_ready,         exp_rdy);
        check_eq("in_ready_nr",      in_ready_nr,      exp_rdy);
        check_eq("out_valid",        out_valid,        m_valid);
        check_eq("out_valid_nr",     out_valid_nr,     m_valid);
        check_eq("group_cnt",        out_group_cnt,    4'(m_cnt));
        check_eq("group_cnt_nr",     out_group_cnt_nr, 4'(m_cnt));
        if (m_valid) begin
            check_eq("out_data",    out_data,    m_word);
            check_eq("out_data_nr", out_data_nr, m_word_nr);
        end
        produced = 1'b0;
        if (v && exp_rdy) begin
            for (int i = 0; i < 8; i++) m_sum[i] += int'($signed(stage[i]));
            if (m_cnt == G - 1) begin
                m_word    = pack_word(m_sum, 1'b1);
                m_word_nr = pack_word(m_sum, 1'b0);
                for (int i = 0; i < 8; i++) m_sum[i] = 0;
                m_cnt    = 0;
                produced = 1'b1;
            end else begin
                m_cnt++;
            end
        end
        if (produced)            m_valid = 1'b1;
        else if (m_valid && ordy) m_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        #1;
        check_eq("rst_out_valid", out_valid,     1'b0);
        check_eq("rst_out_data",  out_data,      128'h0);
        check_eq("rst_group_cnt", out_group_cnt, 4'h0);
        check_eq("rst_in_ready",  in_ready,      1'b1);
        check_eq("rst_data_nr",   out_data_nr,   128'h0);
        model_clear();
        rst = 1'b0;
    endtask

    task automatic fill_stage(input logic [15:0] val);
        for (int i = 0; i < 8; i++) stage[i] = val;
    endtask

    task automatic rand_stage();
        for (int i = 0; i < 8; i++) stage[i] = 16'($urandom);
    endtask

    logic [15:0] mix [4];
    int          ready_low;
    int          words_seen;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        fill_stage(16'h0000);
        for (int i = 0; i < 8; i++) lane[i] = 16'h0000;
        model_clear();
        mix[0] = 16'h0800; mix[1] = 16'hF400; mix[2] = 16'h0200; mix[3] = 16'h0600;

        do_reset();

        // four beats of 1.0 on every lane -> 4.0, visible for exactly one cycle
        fill_stage(16'h0400);
        repeat (4) step(1'b1, 1'b1);
        fill_stage(16'h0000);
        step(1'b0, 1'b1);
        check_eq("t1_valid", out_valid, 1'b1);
        check_eq("t1_word",  out_data,  {8{16'h1000}});
        step(1'b0, 1'b1);
        check_eq("t1_one_cycle", out_valid, 1'b0);

        // saturation high/low, ReLU vs. no ReLU, mixed signs, packing order
        for (int b = 0; b < 4; b++) begin
            fill_stage(16'h0000);
            stage[0] = 16'h7000;
            stage[1] = 16'h9000;
            stage[2] = mix[b];
            stage[7] = 16'h0001;
            step(1'b1, 1'b1);
        end
        fill_stage(16'h0000);
        step(1'b0, 1'b1);
        check_eq("t2_relu",   out_data,    128'h7FFF_0000_0400_0000_0000_0000_0000_0004);
        check_eq("t2_norelu", out_data_nr, 128'h7FFF_8000_0400_0000_0000_0000_0000_0004);
        step(1'b0, 1'b1);

        // downstream stall: non-final beats keep flowing, final beat held off
        repeat (4) begin rand_stage(); step(1'b1, 1'b1); end
        repeat (6) begin rand_stage(); step(1'b1, 1'b0); end
        check_eq("t3_stall_cnt",  out_group_cnt, 4'd3);
        check_eq("t3_blocked",    in_ready,      1'b0);
        rand_stage();
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check_eq("t3_second_word", out_valid, 1'b1);
        step(1'b0, 1'b1);

        // full throughput: one word every G beats, never back-pressured
        ready_low  = 0;
        words_seen = 0;
        repeat (32) begin
            rand_stage();
            step(1'b1, 1'b1);
            if (!in_ready)  ready_low++;
            if (out_valid)  words_seen++;
        end
        step(1'b0, 1'b1);
        if (out_valid) words_seen++;
        check_eq("t4_ready_low", 128'(ready_low),  128'd0);
        check_eq("t4_words",     128'(words_seen), 128'd8);
        step(1'b0, 1'b1);

        // reset mid-word discards partial sums
        repeat (2) begin rand_stage(); step(1'b1, 1'b1); end
        do_reset();
        fill_stage(16'h0400);
        repeat (4) step(1'b1, 1'b1);
        fill_stage(16'h0000);
        step(1'b0, 1'b1);
        check_eq("t5_word",    out_data,    {8{16'h1000}});
        check_eq("t5_word_nr", out_data_nr, {8{16'h1000}});
        step(1'b0, 1'b1);

        // random traffic on both sides
        repeat (800) begin
            rand_stage();
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
        end
        repeat (3) step(1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/layer2_result_collector.md
Name: layer2_result_collector

Overview:
- Consumer end of the layer-2 8-lane conv MAC array. Takes the array's eight signed 16-bit per-beat outputs and accumulates them over GROUPS input-channel groups, because a layer-2 pixel has GROUPS×8 input channels.
- Applies saturation and optional ReLU to each accumulated lane.
- Packs the eight results into one 128-bit word and hands it downstream with a valid/ready handshake.
- Sits between the combinational MAC array and the layer-2 output buffer / write-back logic.

Parameters:
- WORDLENGTH, 16, lane width (fixed-point Q5.10, as produced by the MAC array).
- GROUPS, 4, input beats accumulated per output word; legal range 1..16.
- ACC_WIDTH, 20, internal signed accumulator width per lane; must be ≥ WORDLENGTH+clog2(GROUPS).
- RELU_EN, 1, 1 = clamp negative results to 0 after saturation.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  MAC-array outputs valid this cycle.
- in_ready  output  1  collector accepts a beat this cycle.
- in_channel1..in_channel8  input  16 each  signed lane results from the MAC array.
- out_valid  output  1  out_data holds a finished word.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  128  packed results: lane1 in [127:112] … lane8 in [15:0].
- out_group_cnt  output  4  beats accumulated so far for the current word (debug/status).

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst.
- Reset values:
  - out_valid=0, out_data=0, out_group_cnt=0.
  - All lane accumulators 0.
  - in_ready=1.
- Reset asserted mid-word discards partial sums and any pending output word.
- Beat accepted ⇔ in_valid && in_ready, sampled at the clk rising edge.
- Non-final beat (out_group_cnt < GROUPS-1):
  - acc[i] ← acc[i] + sign-extended in_channel_i.
  - out_group_cnt increments.
- Final beat (out_group_cnt == GROUPS-1):
  - sum[i] = acc[i] + sign-extended in_channel_i.
  - r[i] = sat16(sum[i]): sums > 32767 become 0x7FFF, sums < -32768 become 0x8000.
  - If RELU_EN, negative r[i] become 0x0000.
  - out_data ← packed r[1..8]; out_valid ← 1.
  - All acc cleared to 0; out_group_cnt ← 0.
  - Latency: word visible the cycle after the final beat is accepted.
- Handshake:
  - in_ready = !(out_valid && !out_ready && out_group_cnt == GROUPS-1).
  - Non-final beats are always accepted, even while the output is stalled.
  - Only a final beat that would overwrite an unconsumed word is back-pressured.
  - out_valid clears on the cycle after out_valid && out_ready, unless a new final beat is accepted in that same cycle; then out_valid stays 1 and out_data takes the new word (full throughput, no bubble).
  - out_data and out_valid are stable while out_valid && !out_ready.
  - in_ready has no combinational dependency on in_valid. It depends combinationally on out_ready (the only comb path).
- GROUPS=1: every accepted beat produces a word. Accumulators are effectively unused, but saturation and ReLU still apply (no-op for 16-bit input except ReLU).
- No accumulator overflow is possible within the legal GROUPS range at ACC_WIDTH=20. Saturation is applied only at the output stage.
- State summary:
  - ACC: out_valid=0.
  - HOLD: out_valid=1.
  - ACC→HOLD on final beat.
  - HOLD→ACC on out_ready with no simultaneous final beat.
  - HOLD→HOLD on out_ready together with a final beat, or on !out_ready.

Test Plan:
- Reset then GROUPS=4, lanes all 0x0400 (1.0) for 4 beats, out_ready=1 → one word, every lane 0x1000 (4.0), out_valid for exactly 1 cycle, 1 cycle after 4th beat.
- Lane1 = 0x7000 for 4 beats → lane1 saturates to 0x7FFF; lane2 = 0x9000 ×4 → 0x0000 with RELU_EN=1, 0x8000 with RELU_EN=0.
- Mixed signs: lane3 beats +0x0800, -0x0C00, +0x0200, +0x0600 → 0x0400; packing check lane1 at [127:112], lane8 at [15:0].
- out_ready=0 after first word, keep feeding continuously → beats 1–3 of next word accepted, in_ready drops on final beat, out_data unchanged; raise out_ready → second word issued back-to-back with no bubble, no data lost.
- Continuous in_valid and out_ready=1 for 8 words → one word every 4 cycles, in_ready never low.
- Assert rst after 2 beats of a word → out_group_cnt=0, all accumulators 0; the next 4 beats of 0x0400 yield 0x1000 per lane (no residue from the discarded beats).
